// File: rtl/trivium_pkg.sv
// trivium_pkg: shared constants and sequencer state encoding for the Trivium controller.
package trivium_pkg;
    localparam int TRIV_KEY_W  = 80;
    localparam int TRIV_IV_W   = 80;
    localparam int TRIV_WARMUP = 1152;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_RUN,
        S_DRAIN
    } triv_state_e;
endpackage

// File: rtl/trivium_ks_packer.sv
// trivium_ks_packer: gathers keystream bits into words and holds the last bit back under backpressure.
module trivium_ks_packer #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ks_bit,
    input  logic             ks_ready,
    output logic             step,
    output logic             word_load,
    output logic [OUT_W-1:0] ks_data,
    output logic             ks_valid
);
    localparam int CNT_W = $clog2(OUT_W);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [OUT_W-2:0] sh_q, sh_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last;

    always_comb begin
        last      = bit_cnt_q == CNT_W'(OUT_W - 1);
        step      = en && !(last && valid_q && !ks_ready);
        word_load = step && last;
        sh_d      = sh_q;
        if (step && !last) sh_d[bit_cnt_q] = ks_bit;
        bit_cnt_d = !step ? bit_cnt_q : last ? '0 : bit_cnt_q + 1'b1;
        data_d    = word_load ? {ks_bit, sh_q} : data_q;
        valid_d   = word_load || (valid_q && !ks_ready);
        if (clr) begin
            sh_d      = '0;
            bit_cnt_d = '0;
            data_d    = '0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign ks_data  = data_q;
    assign ks_valid = valid_q;
endmodule

// File: rtl/trivium_ctrl.sv
// trivium_ctrl: sequences load, warm-up and keystream packing for a stepped Trivium core.
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int WARMUP = TRIV_WARMUP,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TRIV_KEY_W-1:0] key,
    input  logic [TRIV_IV_W-1:0]  iv,
    input  logic [LEN_W-1:0]      req_len,
    output logic                  core_load,
    output logic                  core_step,
    output logic [TRIV_KEY_W-1:0] core_key,
    output logic [TRIV_IV_W-1:0]  core_iv,
    input  logic                  core_ks,
    output logic [OUT_W-1:0]      ks_data,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int SC_W = $clog2(WARMUP);

    triv_state_e           state_q, state_d;
    logic [SC_W-1:0]       step_cnt_q, step_cnt_d;
    logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [TRIV_KEY_W-1:0] key_q, key_d;
    logic [TRIV_IV_W-1:0]  iv_q, iv_d;
    logic                  done_q, done_d;
    logic                  pk_step, word_load;

    trivium_ks_packer #(.OUT_W(OUT_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .en       (state_q == S_RUN),
        .ks_bit   (core_ks),
        .ks_ready (ks_ready),
        .step     (pk_step),
        .word_load(word_load),
        .ks_data  (ks_data),
        .ks_valid (ks_valid)
    );

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        key_d      = key_q;
        iv_d       = iv_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d    = S_LOAD;
                key_d      = key;
                iv_d       = iv;
                len_d      = req_len;
                word_cnt_d = '0;
            end
            S_LOAD: begin
                state_d    = S_WARMUP;
                step_cnt_d = '0;
            end
            S_WARMUP: begin
                step_cnt_d = step_cnt_q + 1'b1;
                if (step_cnt_q == SC_W'(WARMUP - 1)) state_d = S_RUN;
            end
            S_RUN: if (word_load) begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (len_q != '0 && word_cnt_d == len_q) state_d = S_DRAIN;
            end
            S_DRAIN: if (ks_valid && ks_ready) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins over everything, including a completing handshake
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            key_q      <= key_d;
            iv_q       <= iv_d;
            done_q     <= done_d;
        end
    end

    assign core_load = state_q == S_LOAD;
    assign core_step = state_q == S_WARMUP || pk_step;
    assign core_key  = key_q;
    assign core_iv   = iv_q;
    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: drives trivium_ctrl against a behavioural Trivium core and scoreboards the keystream.
module tb_trivium_ctrl;
    localparam int OUT_W  = 8;
    localparam int LEN_W  = 16;
    localparam int WARMUP = 1152;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [79:0]      key = '0;
    logic [79:0]      iv = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             ks_ready = 1'b0;
    logic             core_load, core_step, core_ks;
    logic [79:0]      core_key, core_iv;
    logic [OUT_W-1:0] ks_data;
    logic             ks_valid, busy, done;

    trivium_ctrl #(.OUT_W(OUT_W), .WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key      (key),
        .iv       (iv),
        .req_len  (req_len),
        .core_load(core_load),
        .core_step(core_step),
        .core_key (core_key),
        .core_iv  (core_iv),
        .core_ks  (core_ks),
        .ks_data  (ks_data),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [288:1] t_load(input logic [79:0] k, input logic [79:0] v);
        logic [288:1] s = '0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        return s;
    endfunction

    function automatic logic t_z(input logic [288:1] s);
        return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
    endfunction

    function automatic logic [288:1] t_upd(input logic [288:1] s);
        logic [288:1] n;
        logic t1, t2, t3;
        t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
        t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
        t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
        n[93:2]    = s[92:1];
        n[1]       = t3;
        n[177:95]  = s[176:94];
        n[94]      = t1;
        n[288:179] = s[287:178];
        n[178]     = t2;
        return n;
    endfunction

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // behavioural core: the environment the controller sequences
    logic [288:1] cst = '0;
    always @(posedge clk) begin
        if (core_load) cst <= t_load(core_key, core_iv);
        else if (core_step) cst <= t_upd(cst);
    end
    assign core_ks = t_z(cst);

    logic [OUT_W-1:0] exp_q[$];
    int               acc_q[$];
    int               vec = 0, mis = 0, cyc = 0, st_cyc = 0;
    int               done_cnt = 0, load_cnt = 0;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        vec++;
        if (act !== exp_v) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // reference stream: full warm-up from the key/iv, then bit 0 first in each word
    task automatic gen_exp(input logic [79:0] k, input logic [79:0] v, input int n);
        logic [288:1] s = t_load(k, v);
        logic [OUT_W-1:0] w;
        repeat (WARMUP) s = t_upd(s);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < OUT_W; b++) begin
                w[b] = t_z(s);
                s = t_upd(s);
            end
            exp_q.push_back(w);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            chk("load_step_exclusive", 64'(core_load & core_step), 64'd0);
            chk("valid_only_when_busy", 64'(ks_valid & ~busy), 64'd0);
            if (prev_stall && ks_valid) chk("stall_data_stable", 64'(ks_data), 64'(prev_data));
            prev_stall = ks_valid & ~ks_ready;
            prev_data  = ks_data;
            if (core_load) load_cnt++;
            if (ks_valid && ks_ready) begin
                acc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vec++;
                    mis++;
                    $display("FAIL extra_word: got %0h expected none", ks_data);
                end else chk("ks_word", 64'(ks_data), 64'(exp_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", 64'(cyc), acc_q.size() != 0 ? 64'(acc_q[acc_q.size()-1] + 1) : '1);
                chk("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
            end
        end else prev_stall = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sess(input logic [79:0] k, input logic [79:0] v, input logic [LEN_W-1:0] len, input int n);
        key     = k;
        iv      = v;
        req_len = len;
        start   = 1'b1;
        st_cyc  = cyc;
        acc_q.delete();
        gen_exp(k, v, n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rnd) ks_ready = 1'($urandom_range(0, 1));
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vec++;
            mis++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end
        ks_ready = 1'b1;
        tick();
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc_q.size() < n; i++) tick();
        chk("accept_count_reached", 64'(acc_q.size() >= n), 64'd1);
    endtask

    initial begin
        logic [79:0] k2, v2;
        int steps, ld0, d0;
        repeat (3) tick();
        chk("rst_core_load", 64'(core_load), 64'd0);
        chk("rst_core_step", 64'(core_step), 64'd0);
        chk("rst_ks_valid", 64'(ks_valid), 64'd0);
        chk("rst_ks_data", 64'(ks_data), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_key_iv", 64'({|core_key, |core_iv}), 64'd0);
        rst = 1'b1;
        tick();

        // zero key/iv, 4 words, exact timing
        ks_ready = 1'b1;
        begin_sess('0, '0, 16'd4, 4);
        chk("load_cycle1", 64'(core_load), 64'd1);
        chk("no_step_cycle1", 64'(core_step), 64'd0);
        steps = 0;
        for (int c = 2; c <= 1162; c++) begin
            tick();
            if (core_step) steps++;
            if (c == 2) chk("load_one_cycle", 64'(core_load), 64'd0);
            if (c == 1153) chk("warmup_steps", 64'(steps), 64'd1152);
            if (c == 1161) chk("valid_before_1162", 64'(ks_valid), 64'd0);
            if (c == 1162) chk("valid_at_1162", 64'(ks_valid), 64'd1);
        end
        wait_done(100, 1'b0);
        chk("t1_words", 64'(acc_q.size()), 64'd4);
        chk("t1_first_accept", 64'(acc_q[0] - st_cyc), 64'd1162);
        chk("t1_word_spacing", 64'(acc_q[3] - acc_q[0]), 64'd24);
        chk("t1_done_once", 64'(done_cnt), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // backpressure stall plus ignored starts during WARMUP and RUN
        k2 = rnd80();
        v2 = rnd80();
        ld0 = load_cnt;
        d0 = done_cnt;
        begin_sess(k2, v2, 16'd12, 12);
        repeat (500) tick();
        key = ~k2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_warmup_key", 64'(core_key == k2), 64'd1);
        wait_acc(3, 2000);
        iv = ~v2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_run_iv", 64'(core_iv == v2), 64'd1);
        ks_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= 17) chk("stall_no_step", 64'(core_step), 64'd0);
            if (i == 20) chk("stall_valid_held", 64'(ks_valid), 64'd1);
        end
        ks_ready = 1'b1;
        wait_done(500, 1'b0);
        chk("t2_single_load", 64'(load_cnt - ld0), 64'd1);
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        tick();
        chk("start_abort_no_load", 64'(core_load | busy), 64'd0);

        // unlimited length, abort after 100 words
        d0 = done_cnt;
        begin_sess(rnd80(), rnd80(), '0, 130);
        wait_acc(100, 3000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(ks_valid), 64'd0);
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        exp_q.delete();

        // reset during warm-up, then a full fresh session
        begin_sess(rnd80(), rnd80(), 16'd2, 0);
        repeat (300) tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_outputs", 64'({core_load, core_step, ks_valid, busy, done}), 64'd0);
        chk("mid_rst_key_iv", 64'({|core_key, |core_iv}), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        begin_sess(rnd80(), rnd80(), 16'd2, 2);
        wait_done(1300, 1'b0);
        chk("restart_first_accept", 64'(acc_q[0] - st_cyc), 64'd1162);
        chk("restart_done_once", 64'(done_cnt - d0), 64'd1);

        // long run with random backpressure
        d0 = done_cnt;
        begin_sess(rnd80(), rnd80(), 16'd1000, 1000);
        wait_done(40000, 1'b1);
        chk("long_done_once", 64'(done_cnt - d0), 64'd1);
        chk("long_all_words", 64'(acc_q.size()), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
